alu_issue_stage: RTL
====================

# alu_issue_stage

Command-issue stage that sits directly upstream of the 8-bit combinational ALU and captures its result. It accepts operand/opcode commands over a valid/ready handshake, buffers them in a small FIFO, and presents the head entry to the ALU inputs. It registers the 16-bit ALU result, with a zero flag, into an output slot that has its own valid/ready handshake, so the datapath tolerates backpressure from both sides.

## Interface
- DEPTH, 4, command FIFO entries; power of two, 2..16.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  command present on in_operand1/in_operand2/in_opcode.
- in_ready  out  1  stage can accept a command this cycle.
- in_operand1  in  8  first operand.
- in_operand2  in  8  second operand.
- in_opcode  in  4  ALU opcode, passed through unmodified.
- alu_operand1  out  8  to ALU operand1.
- alu_operand2  out  8  to ALU operand2.
- alu_opcode  out  4  to ALU opcode.
- alu_result  in  16  from ALU result; combinational function of the alu_* outputs.
- out_valid  out  1  out_result, out_opcode and out_zero are valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_result  out  16  captured ALU result.
- out_opcode  out  4  opcode that produced out_result.
- out_zero  out  1  1 when out_result == 16'h0000.
- fifo_count  out  $clog2(DEPTH)+1  number of occupied FIFO entries.

## Operation
- Push: push = in_valid && in_ready. It writes {operand1, operand2, opcode} at the write pointer.
- in_ready = (fifo_count < DEPTH). It depends only on occupancy, so a full FIFO refuses a push even in a cycle where it pops.
- Head drive:
  - When fifo_count != 0, alu_operand1/alu_operand2/alu_opcode = the head entry, read combinationally from storage.
  - When the FIFO is empty, all three are driven 0.
- Pop: pop = (fifo_count != 0) && (!out_valid || out_ready). On pop:
  - out_result <= alu_result;
  - out_opcode <= head opcode;
  - out_zero <= (alu_result == 0);
  - out_valid <= 1;
  - the read pointer advances.
- Output drain: out_valid clears when out_ready && out_valid && !pop. If out_ready and pop occur together, out_valid stays 1 and the data is replaced (back-to-back, one result per cycle).
- out_result/out_opcode/out_zero hold their value while out_valid && !out_ready.
- Occupancy: a simultaneous push and pop leaves fifo_count unchanged. Pointers wrap modulo DEPTH.
- The stage never inspects the opcode. Results and flags are exactly what the ALU returns. out_zero is computed on all 16 bits.
- Reset (async, any time, including mid-transfer) forces:
  - both pointers = 0, fifo_count = 0, in_ready = 1;
  - out_valid = 0, out_result = 0, out_opcode = 0, out_zero = 0;
  - alu_* = 0.
- Buffered commands are discarded on reset. Removing reset does not replay them.

## Timing
- Minimum latency: a command pushed at edge N is at the FIFO head after N. It is captured and out_valid = 1 after edge N+1, provided the output slot is free.
- Sustained throughput is one command per cycle with out_ready held at 1.
- The ALU is combinational. The path is FIFO storage -> alu_* -> alu_result -> out_result within one cycle; no extra pipeline register.
- in_ready and fifo_count are registered-state-derived. They have no combinational path from in_valid or out_ready.
- pop depends combinationally on out_ready.
- Maximum buffered commands = DEPTH in the FIFO plus 1 in the output slot.

## Test plan
- Reset then single add: push operand1 = 200, operand2 = 100, opcode 0000 -> two edges later out_valid = 1, out_result = 16'h012C, out_zero = 0, out_opcode = 0000.
- Width checks, back-to-back with out_ready = 1:
  - push 5-10, opcode 0001 -> out_result = 16'hFFFB;
  - then 255*255, opcode 0010 -> out_result = 16'hFE01 on the next cycle;
  - then 8'hA5 XOR 8'hA5, opcode 1001 -> out_result = 0, out_zero = 1.
  - Expect results in three consecutive cycles with out_valid continuously 1.
- Backpressure: out_ready = 0, in_valid held with 6 distinct commands (DEPTH = 4) -> exactly 5 accepted (1 in output slot, 4 in FIFO). Then in_ready = 0 and fifo_count = 4. Release out_ready -> 5 results emerge in push order, one per cycle.
- Full with simultaneous pop: FIFO full, out_ready = 1, in_valid = 1 -> no push that cycle, fifo_count goes 4 -> 3. in_ready = 1 on the following cycle.
- Empty drive and wrap: with FIFO empty, alu_* = 0 and out_valid falls after the final out_ready handshake. Push 9 single commands one at a time -> pointers wrap twice, and every result matches its command.
- Async reset mid-operation: assert rst_n = 0 between edges with fifo_count = 3 and out_valid = 1 -> immediately out_valid = 0, in_ready = 1, fifo_count = 0. No stale result appears after release.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: command FIFO feeding a combinational ALU, plus a
// registered result slot with its own valid/ready handshake.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready            command handshake
//   in_operand1/2, in_opcode     command fields
//   alu_operand1/2, alu_opcode   head entry driven to the ALU (0 when empty)
//   alu_result                   combinational ALU result
//   out_valid/out_ready          result handshake
//   out_result/opcode/zero       captured result, its opcode, zero flag
//   fifo_count                   occupied FIFO entries
module alu_issue_stage #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_operand1,
  input  logic [7:0]               in_operand2,
  input  logic [3:0]               in_opcode,
  output logic [7:0]               alu_operand1,
  output logic [7:0]               alu_operand2,
  output logic [3:0]               alu_opcode,
  input  logic [15:0]              alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_result,
  output logic [3:0]               out_opcode,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [7:0] op1;
    logic [7:0] op2;
    logic [3:0] opc;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  cmd_t          wr_cmd;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty      = (count == '0);
  assign in_ready   = (count < CW'(DEPTH));
  assign fifo_count = count;
  assign push       = in_valid && in_ready;
  // Pop whenever the slot is free or being drained this cycle.
  assign pop        = !empty && (!out_valid || out_ready);

  assign wr_cmd = '{op1: in_operand1,
                    op2: in_operand2,
                    opc: in_opcode};
  assign head   = mem[rd_ptr];

  always_comb begin
    alu_operand1 = '0;
    alu_operand2 = '0;
    alu_opcode   = '0;
    if (!empty) begin
      alu_operand1 = head.op1;
      alu_operand2 = head.op2;
      alu_opcode   = head.opc;
    end
  end

  // Storage is not reset; the empty gate above hides stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_opcode <= '0;
      out_zero   <= 1'b0;
    end else if (pop) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_opcode <= head.opc;
      out_zero   <= (alu_result == 16'h0000);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
